// File: rtl/fifo18_rx_arb2.sv
// Round-robin, frame-granular drain of two 18-bit GMII RX FIFOs into one shared FIFO; read issued in t, data sampled t+1, written t+2.
// Backpressure: out_full stalls new reads only (in-flight word still lands); truncation drain ignores out_full.
module fifo18_rx_arb2 #(
    parameter logic [11:0] MAX_WORDS = 12'd800
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [17:0] in0_dout,
    input  logic        in0_empty,
    output logic        in0_rd_en,
    input  logic [17:0] in1_dout,
    input  logic        in1_empty,
    output logic        in1_rd_en,
    output logic [17:0] out_din,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic        cur_port,
    output logic        busy,
    output logic [15:0] frame_count0,
    output logic [15:0] frame_count1,
    output logic [7:0]  trunc_count0,
    output logic [7:0]  trunc_count1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN_ISSUE,
        S_DRAIN_WAIT
    } state_t;

    state_t      r_state;
    logic        r_last_port;
    logic        r_started;
    logic [11:0] r_wcnt;

    logic [17:0] w_dat;
    logic        w_eof;
    logic        w_cur_empty;
    logic        w_rd_out;
    logic        w_any_req;
    logic        w_grant;
    logic        w_can_issue;

    assign w_dat       = cur_port ? in1_dout : in0_dout;
    assign w_eof       = (w_dat[17:16] == 2'b00);
    assign w_cur_empty = cur_port ? in1_empty : in0_empty;
    assign w_rd_out    = in0_rd_en | in1_rd_en;
    assign w_any_req   = !in0_empty || !in1_empty;
    assign w_grant     = (!in0_empty && !in1_empty) ? ~r_last_port : in0_empty;
    assign w_can_issue = !w_cur_empty && !out_full;
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state      <= S_IDLE;
            in0_rd_en    <= 1'b0;
            in1_rd_en    <= 1'b0;
            out_wr_en    <= 1'b0;
            out_din      <= 18'h0;
            cur_port     <= 1'b0;
            r_last_port  <= 1'b1;
            r_started    <= 1'b0;
            r_wcnt       <= 12'd0;
            frame_count0 <= 16'd0;
            frame_count1 <= 16'd0;
            trunc_count0 <= 8'd0;
            trunc_count1 <= 8'd0;
        end else begin
            in0_rd_en <= 1'b0;
            in1_rd_en <= 1'b0;
            out_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        cur_port  <= w_grant;
                        r_started <= 1'b0;
                        r_wcnt    <= 12'd0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_can_issue) begin
                        in0_rd_en <= ~cur_port;
                        in1_rd_en <= cur_port;
                        r_state   <= S_WAIT;
                    end else if (w_cur_empty && !r_started) begin
                        r_state <= S_IDLE;
                    end
                end
                // First WAIT cycle is the read strobe itself; the FIFO word is valid one cycle later.
                S_WAIT: begin
                    if (!w_rd_out) begin
                        if (w_eof) begin
                            if (r_started) begin
                                out_din     <= 18'h0;
                                out_wr_en   <= 1'b1;
                                r_last_port <= cur_port;
                                if (cur_port) frame_count1 <= frame_count1 + 16'd1;
                                else          frame_count0 <= frame_count0 + 16'd1;
                            end
                            r_state <= S_IDLE;
                        end else if (r_wcnt < MAX_WORDS) begin
                            out_din   <= w_dat;
                            out_wr_en <= 1'b1;
                            r_wcnt    <= r_wcnt + 12'd1;
                            r_started <= 1'b1;
                            // Re-issue straight away to reach one word per two clocks.
                            if (w_can_issue) begin
                                in0_rd_en <= ~cur_port;
                                in1_rd_en <= cur_port;
                            end else begin
                                r_state <= S_ISSUE;
                            end
                        end else begin
                            out_din     <= 18'h0;
                            out_wr_en   <= 1'b1;
                            r_last_port <= cur_port;
                            if (cur_port) begin
                                if (trunc_count1 != 8'hff) trunc_count1 <= trunc_count1 + 8'd1;
                            end else begin
                                if (trunc_count0 != 8'hff) trunc_count0 <= trunc_count0 + 8'd1;
                            end
                            r_state <= S_DRAIN_ISSUE;
                        end
                    end
                end
                S_DRAIN_ISSUE: begin
                    if (!w_cur_empty) begin
                        in0_rd_en <= ~cur_port;
                        in1_rd_en <= cur_port;
                        r_state   <= S_DRAIN_WAIT;
                    end
                end
                S_DRAIN_WAIT: begin
                    if (!w_rd_out) r_state <= w_eof ? S_IDLE : S_DRAIN_ISSUE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo18_rx_arb2.sv
// Bench for fifo18_rx_arb2: two input FIFO models, output scoreboard and a read-protocol monitor.
module tb_fifo18_rx_arb2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [17:0] in0_dout = 18'h0;
    logic [17:0] in1_dout = 18'h0;
    logic        in0_empty = 1'b1;
    logic        in1_empty = 1'b1;
    logic        out_full = 1'b0;
    logic        in0_rd_en, in1_rd_en, out_wr_en, cur_port, busy;
    logic [17:0] out_din;
    logic [15:0] frame_count0, frame_count1;
    logic [7:0]  trunc_count0, trunc_count1;

    int total = 0;
    int bad = 0;
    int viol = 0;
    int rd0_cnt = 0;
    int rd1_cnt = 0;
    bit prev_rd = 1'b0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [17:0] got_d[$];
    logic        got_p[$];
    logic [17:0] exp_d[$];
    logic        exp_p[$];

    always #5 sys_clk = ~sys_clk;

    fifo18_rx_arb2 #(.MAX_WORDS(12'd4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in0_dout(in0_dout), .in0_empty(in0_empty), .in0_rd_en(in0_rd_en),
        .in1_dout(in1_dout), .in1_empty(in1_empty), .in1_rd_en(in1_rd_en),
        .out_din(out_din), .out_wr_en(out_wr_en), .out_full(out_full),
        .cur_port(cur_port), .busy(busy),
        .frame_count0(frame_count0), .frame_count1(frame_count1),
        .trunc_count0(trunc_count0), .trunc_count1(trunc_count1)
    );

    // Standard (non-FWFT) FIFO models: data one cycle after rd_en, empty updated at the clock.
    always @(posedge sys_clk) begin
        if (in0_rd_en && q0.size() > 0) in0_dout <= q0.pop_front();
        if (in1_rd_en && q1.size() > 0) in1_dout <= q1.pop_front();
        in0_empty <= (q0.size() == 0);
        in1_empty <= (q1.size() == 0);
    end

    always @(negedge sys_clk) begin
        if (out_wr_en) begin
            got_d.push_back(out_din);
            got_p.push_back(cur_port);
        end
        if (in0_rd_en && in1_rd_en) viol++;
        if ((in0_rd_en && in0_empty) || (in1_rd_en && in1_empty)) viol++;
        if ((in0_rd_en || in1_rd_en) && prev_rd) viol++;
        prev_rd = in0_rd_en || in1_rd_en;
        if (in0_rd_en) rd0_cnt++;
        if (in1_rd_en) rd1_cnt++;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clr();
        got_d.delete(); got_p.delete(); exp_d.delete(); exp_p.delete();
    endtask

    // Push a stimulus word to a port; expect_it queues the word the output should carry.
    task automatic stim(input bit port, input logic [17:0] w, input bit expect_it);
        if (port) q1.push_back(w);
        else      q0.push_back(w);
        if (expect_it) begin
            exp_d.push_back((w[17:16] == 2'b00) ? 18'h0 : w);
            exp_p.push_back(port);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (q0.size() == 0 && q1.size() == 0 && in0_empty && in1_empty && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic wait_got(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (got_d.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({in0_rd_en, in1_rd_en, out_wr_en, busy, cur_port} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000", {in0_rd_en, in1_rd_en, out_wr_en, busy, cur_port});
        end
        total++;
        if (out_din !== 18'h0) begin bad++; $display("FAIL reset_din: got %h want 00000", out_din); end
        total++;
        if ({frame_count0, frame_count1, trunc_count0, trunc_count1} !== 48'h0) begin
            bad++; $display("FAIL reset_cnt: got %h want 0", {frame_count0, frame_count1, trunc_count0, trunc_count1});
        end
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_port0_only();
        bit ok;
        clr();
        stim(0, 18'h3_0102, 1); stim(0, 18'h3_0304, 1); stim(0, 18'h0, 1);
        stim(0, 18'h0, 0); stim(0, 18'h0, 0);
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL p0_timeout: got busy want idle"); end
        total++;
        if (got_d.size() !== exp_d.size()) begin bad++; $display("FAIL p0_len: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                bad++; $display("FAIL p0_word[%0d]: got %h/p%0d want %h/p%0d", i, got_d[i], got_p[i], exp_d[i], exp_p[i]);
            end
        end
        total++;
        if (frame_count0 !== 16'd1) begin bad++; $display("FAIL p0_fc0: got %0d want 1", frame_count0); end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL p0_rd_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_both_ports();
        bit ok;
        clr();
        sys_rst_n = 1'b0;
        stim(0, 18'h3_A1A1, 1); stim(0, 18'h3_A2A2, 1); stim(0, 18'h0, 1);
        stim(1, 18'h3_B1B1, 1); stim(1, 18'h3_B2B2, 1); stim(1, 18'h0_BEEF, 1);
        repeat (3) tick();
        sys_rst_n = 1'b1;
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL both_timeout: got busy want idle"); end
        total++;
        if (got_d.size() !== exp_d.size()) begin bad++; $display("FAIL both_len: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                bad++; $display("FAIL both_word[%0d]: got %h/p%0d want %h/p%0d", i, got_d[i], got_p[i], exp_d[i], exp_p[i]);
            end
        end
        total++;
        if (cur_port !== 1'b1) begin bad++; $display("FAIL both_cur_port: got %0d want 1", cur_port); end
        total++;
        if (frame_count0 !== 16'd1 || frame_count1 !== 16'd1) begin
            bad++; $display("FAIL both_fc: got %0d/%0d want 1/1", frame_count0, frame_count1);
        end
    endtask

    task automatic test_hold_grant();
        bit ok;
        int rd1_snap;
        clr();
        stim(0, 18'h3_C1C1, 1); stim(0, 18'h3_C2C2, 1);
        stim(1, 18'h3_D1D1, 0); stim(1, 18'h3_D2D2, 0); stim(1, 18'h0, 0);
        wait_got(2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_start: got %0d words want 2", got_d.size()); end
        rd1_snap = rd1_cnt;
        repeat (20) tick();
        total++;
        if (rd1_cnt !== rd1_snap) begin bad++; $display("FAIL hold_rd1: got %0d reads want 0", rd1_cnt - rd1_snap); end
        total++;
        if (busy !== 1'b1 || cur_port !== 1'b0) begin bad++; $display("FAIL hold_grant: got busy=%0d port=%0d want 1/0", busy, cur_port); end
        stim(0, 18'h2_5500, 1); stim(0, 18'h0, 1);
        exp_d.push_back(18'h3_D1D1); exp_p.push_back(1'b1);
        exp_d.push_back(18'h3_D2D2); exp_p.push_back(1'b1);
        exp_d.push_back(18'h0);      exp_p.push_back(1'b1);
        wait_idle(ok);
        total++;
        if (got_d.size() !== exp_d.size()) begin bad++; $display("FAIL hold_len: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                bad++; $display("FAIL hold_word[%0d]: got %h/p%0d want %h/p%0d", i, got_d[i], got_p[i], exp_d[i], exp_p[i]);
            end
        end
        total++;
        if (frame_count0 !== 16'd2 || frame_count1 !== 16'd2) begin
            bad++; $display("FAIL hold_fc: got %0d/%0d want 2/2", frame_count0, frame_count1);
        end
    endtask

    task automatic test_truncation();
        bit ok;
        clr();
        for (int i = 1; i <= 6; i++) stim(1, 18'h3_E000 + 18'(i), i <= 4);
        stim(1, 18'h0, 0);
        exp_d.push_back(18'h0); exp_p.push_back(1'b1);
        wait_idle(ok);
        for (int i = 1; i <= 4; i++) stim(0, 18'h3_6000 + 18'(i), 1);
        stim(0, 18'h0, 1);
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL trunc_timeout: got busy want idle"); end
        total++;
        if (got_d.size() !== exp_d.size()) begin bad++; $display("FAIL trunc_len: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                bad++; $display("FAIL trunc_word[%0d]: got %h/p%0d want %h/p%0d", i, got_d[i], got_p[i], exp_d[i], exp_p[i]);
            end
        end
        total++;
        if (trunc_count1 !== 8'd1 || frame_count1 !== 16'd2) begin
            bad++; $display("FAIL trunc_cnt1: got tc=%0d fc=%0d want 1/2", trunc_count1, frame_count1);
        end
        total++;
        if (trunc_count0 !== 8'd0 || frame_count0 !== 16'd3) begin
            bad++; $display("FAIL trunc_cnt0: got tc=%0d fc=%0d want 0/3", trunc_count0, frame_count0);
        end
    endtask

    task automatic test_out_full();
        bit ok;
        int rd_snap;
        clr();
        stim(0, 18'h3_7101, 1); stim(0, 18'h3_7202, 1); stim(0, 18'h3_7303, 1); stim(0, 18'h0, 1);
        wait_got(1, ok);
        out_full = 1'b1;
        tick();
        rd_snap = rd0_cnt + rd1_cnt;
        repeat (9) tick();
        total++;
        if (rd0_cnt + rd1_cnt !== rd_snap) begin
            bad++; $display("FAIL full_rd: got %0d reads want 0", rd0_cnt + rd1_cnt - rd_snap);
        end
        out_full = 1'b0;
        wait_idle(ok);
        total++;
        if (got_d.size() !== exp_d.size()) begin bad++; $display("FAIL full_len: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                bad++; $display("FAIL full_word[%0d]: got %h/p%0d want %h/p%0d", i, got_d[i], got_p[i], exp_d[i], exp_p[i]);
            end
        end
        total++;
        if (frame_count0 !== 16'd4) begin bad++; $display("FAIL full_fc0: got %0d want 4", frame_count0); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        clr();
        stim(0, 18'h3_8101, 0); stim(0, 18'h3_8202, 0); stim(0, 18'h3_8303, 0); stim(0, 18'h0, 0);
        wait_got(1, ok);
        sys_rst_n = 1'b0;
        q0.delete();
        tick();
        total++;
        if ({in0_rd_en, in1_rd_en, out_wr_en, busy, cur_port} !== 5'b0 || out_din !== 18'h0) begin
            bad++; $display("FAIL mrst_outputs: got ctrl=%b din=%h want 00000/00000", {in0_rd_en, in1_rd_en, out_wr_en, busy, cur_port}, out_din);
        end
        total++;
        if ({frame_count0, frame_count1, trunc_count0, trunc_count1} !== 48'h0) begin
            bad++; $display("FAIL mrst_cnt: got %h want 0", {frame_count0, frame_count1, trunc_count0, trunc_count1});
        end
        sys_rst_n = 1'b1;
        clr();
        repeat (4) tick();
        stim(0, 18'h3_9101, 1); stim(0, 18'h3_9202, 1); stim(0, 18'h0, 1);
        wait_idle(ok);
        total++;
        if (got_d.size() !== exp_d.size()) begin bad++; $display("FAIL mrst_len: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                bad++; $display("FAIL mrst_word[%0d]: got %h/p%0d want %h/p%0d", i, got_d[i], got_p[i], exp_d[i], exp_p[i]);
            end
        end
        total++;
        if (frame_count0 !== 16'd1) begin bad++; $display("FAIL mrst_fc0: got %0d want 1", frame_count0); end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL rd_protocol: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_port0_only();
        test_both_ports();
        test_hold_grant();
        test_truncation();
        test_out_full();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
